qos_vc_flow_ctrl: RTL and testbench
===================================

Name: qos_vc_flow_ctrl

Overview:
- Receive-side QoS flow-control block; it is the responder to the VC traffic transmitter.
- Accepts DataWord pushes tagged with VC_ID into four per-VC FIFOs.
- Per VC, generates Pause_stb/Continue_stb watermark strobes from programmable percentage thresholds, plus Error_full on overflow.
- Drains the FIFOs round-robin onto a single output when Pop_buffer is asserted.

Parameters:
- DATA_W, 4, DataWord / Data_out width
- DEPTH, 4, entries per VC FIFO (power of two, >=2)
- NUM_VC, 4, number of virtual channels (fixed 4; VC_ID is 2 bits)

Ports:
- CLK  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Set_init  in  1  config mode: latch Th_L/Th_H, flush FIFOs
- Th_L  in  7  low watermark, percent 0-100
- Th_H  in  7  high watermark, percent 0-100
- Push_fifos  in  1  push DataWord into FIFO VC_ID
- VC_ID  in  2  target VC of push
- DataWord  in  DATA_W  push data
- Pop_buffer  in  1  request one word, round-robin
- Data_out  out  DATA_W  popped word (registered)
- VC_out  out  2  VC of popped word
- Valid_out  out  1  Data_out/VC_out valid this cycle
- Pause_stb  out  4  per-VC one-cycle pause pulse
- Continue_stb  out  4  per-VC one-cycle resume pulse
- Error_full  out  4  per-VC one-cycle overflow pulse
- Idle  out  1  all FIFOs empty

Behaviour:
Reset:
- All outputs are 0, except Idle=1.
- Counts and pointers are 0; every VC is in FLOW; round-robin pointer rr=0.
- Latched thresholds reset to thL=25, thH=75.
- Asserting Reset mid-operation discards all contents immediately; no strobes are issued.

Set_init=1:
- Push and pop are ignored; all FIFOs are flushed; all VCs go to FLOW.
- Thresholds are latched each cycle, clamped to 100.
- If Th_L >= Th_H, thL = thH - 1 (saturating at 0).
- Strobes and Valid_out are 0.

Occupancy and ordering:
- occ[v] ranges 0..DEPTH.
- Within a cycle, the pop is evaluated before the push.

Push:
- Push to a VC with occ < DEPTH, or a VC being popped in the same cycle, is accepted.
- Push to a full VC that is not being popped drops the word and sets Error_full[v]=1 on the next cycle.

Pop:
- If Pop_buffer=1, search VC rr, rr+1, ... (mod 4) for the first non-empty FIFO v.
- Next cycle: Data_out = head of v, VC_out = v, Valid_out = 1; rr becomes v+1.
- If all FIFOs are empty: Valid_out=0 and rr is unchanged.
- Latency is 1 cycle. Data_out/VC_out hold their value when Valid_out=0.

Watermarks (compare against post-update occupancy occ_n):
- High: occ_n*100 >= thH*DEPTH.
- Low: occ_n*100 <= thL*DEPTH.
- Arithmetic is unsigned at width 7+clog2(DEPTH)+1; no truncation.

Per-VC FSM, states FLOW and PAUSED:
- FLOW -> PAUSED when High is true: Pause_stb[v]=1 for one cycle, the cycle after the causing edge.
- PAUSED -> FLOW when Low is true: Continue_stb[v]=1 for one cycle.
- No repeated Pause while PAUSED. Pause and Continue are never both 1 for the same VC.

Idle:
- Idle=1 iff all occ==0; registered.
- Idle updates in the same cycle the counts update.

Optional Feature:
Macro STICKY_ERROR_EN.
- Defined: each Error_full[v] bit stays set after an overflow until Reset or Set_init.
- Undefined: Error_full is a one-cycle pulse per dropped word.
- Push/drop behaviour is identical in both cases.

Decomposition:
- Package qos_pkg holds:
  - NUM_VC=4, VC_W=2, PCT_MAX=100
  - Reset defaults TH_L_RST=25, TH_H_RST=75
  - fc_state_t enum {FLOW, PAUSED}
- Sub-module qos_vc_fifo: a single-VC circular FIFO with occ count, push/pop, full/empty. It is instantiated NUM_VC times.
- Watermark compare, FSM, round-robin and strobe logic stay in the top level.

Test Plan:
1. Reset; Set_init with Th_L=25, Th_H=75; push VC0 words 0,1,2 on consecutive cycles -> Pause_stb=4'b0001 for exactly one cycle, after the 3rd push (occ=3); Idle goes 0 after the 1st push.
2. From (1): pop 2x with only VC0 non-empty -> Data_out 0 then 1, VC_out=0; Continue_stb=4'b0001 once, when occ reaches 1.
3. Push VC1 x4, then a 5th push of 4'd9 to VC1 -> Error_full=4'b0010 one cycle (sticky under STICKY_ERROR_EN); the word is not later popped. Then a simultaneous push+pop on full VC1 -> no error, occ stays 4.
4. One word each in VC0..VC3, rr=0, Pop_buffer held 5 cycles -> VC_out 0,1,2,3, then Valid_out=0; Idle=1 after the 4th pop.
5. Set_init with Th_L=80, Th_H=60 -> thL latched 59; Th_H=120 -> thH latched 100. With thH=100 and DEPTH=4, Pause fires only at occ=4.
6. Assert Reset while VC2 is PAUSED with 3 entries -> outputs 0 and Idle=1 asynchronously; no Continue_stb; after release, a pop gives Valid_out=0.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared types and constants for the QoS virtual-channel flow-control block.
// Optional feature macro used by the top level: STICKY_ERROR_EN.
package qos_pkg;

  localparam int NUM_VC   = 4;
  localparam int VC_W     = 2;
  localparam int TH_W     = 7;
  localparam int PCT_MAX  = 100;
  localparam int TH_L_RST = 25;
  localparam int TH_H_RST = 75;

  typedef enum logic {
    FLOW,
    PAUSED
  } fc_state_t;

  // Limit a percentage input to the 0..100 range
  function automatic logic [TH_W-1:0] clampPct(input logic [TH_W-1:0] pct);
    return (pct > TH_W'(PCT_MAX)) ? TH_W'(PCT_MAX) : pct;
  endfunction

endpackage

// File: rtl/qos_vc_fifo.sv
// Single-VC circular FIFO with occupancy count. The head word is visible
// combinationally so the parent can register it on a pop. A push to a full
// FIFO is only taken when a pop frees a slot in the same cycle.
module qos_vc_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   occ_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rdPtr_q, wrPtr_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              doPop, doPush;

  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign head_o  = mem_q[rdPtr_q];
  assign occ_o   = occ_q;

  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  // Next occupancy after the pop and push of this cycle
  always_comb begin
    occ_d = occ_q;
    if (doPush && !doPop)      occ_d = occ_q + OCC_W'(1);
    else if (doPop && !doPush) occ_d = occ_q - OCC_W'(1);
  end

  // Pointer and count registers; flush empties the FIFO without touching storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      occ_q   <= '0;
    end else if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      occ_q   <= '0;
    end else begin
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  // Storage write; contents are only meaningful while counted in occ_q
  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/qos_vc_flow_ctrl.sv
// Receive-side QoS flow control: four per-VC FIFOs, percentage watermark
// pause/continue strobes, overflow flags and a round-robin drain port.
// Optional feature macro: STICKY_ERROR_EN (overflow flags held until cleared).
module qos_vc_flow_ctrl
  import qos_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Set_init,
  input  logic [6:0]        Th_L,
  input  logic [6:0]        Th_H,
  input  logic              Push_fifos,
  input  logic [1:0]        VC_ID,
  input  logic [DATA_W-1:0] DataWord,
  input  logic              Pop_buffer,
  output logic [DATA_W-1:0] Data_out,
  output logic [1:0]        VC_out,
  output logic              Valid_out,
  output logic [3:0]        Pause_stb,
  output logic [3:0]        Continue_stb,
  output logic [3:0]        Error_full,
  output logic              Idle
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int WM_W  = TH_W + $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] head [NUM_VC];
  logic [OCC_W-1:0]  occ  [NUM_VC];
  logic [OCC_W-1:0]  occN [NUM_VC];
  logic [NUM_VC-1:0] full, empty, pushAcc, popSel, errD, pauseD, contD, hiHit, loHit;
  logic              popHit, idleD;
  logic [VC_W-1:0]   popVc, rr_q;
  logic [TH_W-1:0]   thL_q, thH_q, thLc, thHc, thLd;
  fc_state_t         state_q [NUM_VC];
  fc_state_t         state_d [NUM_VC];
  logic [DATA_W-1:0] dataOut_q;
  logic [VC_W-1:0]   vcOut_q;
  logic              valid_q, idle_q;
  logic [NUM_VC-1:0] pause_q, cont_q, err_q;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    qos_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (CLK),
      .rst_i   (Reset),
      .flush_i (Set_init),
      .push_i  (pushAcc[v]),
      .pop_i   (popSel[v]),
      .data_i  (DataWord),
      .head_o  (head[v]),
      .occ_o   (occ[v]),
      .full_o  (full[v]),
      .empty_o (empty[v])
    );
  end

  // Round-robin search for the first non-empty VC starting at rr
  always_comb begin
    popSel = '0;
    popHit = 1'b0;
    popVc  = rr_q;
    if (Pop_buffer && !Set_init) begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (!popHit && !empty[rr_q + VC_W'(i)]) begin
          popHit = 1'b1;
          popVc  = rr_q + VC_W'(i);
        end
      end
      if (popHit) popSel[popVc] = 1'b1;
    end
  end

  // Push acceptance, seeing this cycle's pop first; a refused push flags overflow
  always_comb begin
    pushAcc = '0;
    errD    = '0;
    if (Push_fifos && !Set_init) begin
      if (!full[VC_ID] || popSel[VC_ID]) pushAcc[VC_ID] = 1'b1;
      else                               errD[VC_ID]    = 1'b1;
    end
  end

  // Post-update occupancy, watermark hits and the all-empty flag
  always_comb begin
    idleD = 1'b1;
    hiHit = '0;
    loHit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      occN[v]  = occ[v] + OCC_W'(pushAcc[v]) - OCC_W'(popSel[v]);
      hiHit[v] = (WM_W'(occN[v]) * WM_W'(PCT_MAX)) >= (WM_W'(thH_q) * WM_W'(DEPTH));
      loHit[v] = (WM_W'(occN[v]) * WM_W'(PCT_MAX)) <= (WM_W'(thL_q) * WM_W'(DEPTH));
      if (occN[v] != '0) idleD = 1'b0;
    end
    if (Set_init) idleD = 1'b1;
  end

  // Per-VC pause/continue next state and strobes
  always_comb begin
    pauseD = '0;
    contD  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      state_d[v] = state_q[v];
      if (Set_init) begin
        state_d[v] = FLOW;
      end else begin
        case (state_q[v])
          FLOW: if (hiHit[v]) begin
            state_d[v] = PAUSED;
            pauseD[v]  = 1'b1;
          end
          PAUSED: if (loHit[v]) begin
            state_d[v] = FLOW;
            contD[v]   = 1'b1;
          end
          default: state_d[v] = FLOW;
        endcase
      end
    end
  end

  // Threshold sanitising: clamp to 100 and keep low strictly below high
  always_comb begin
    thHc = clampPct(Th_H);
    thLc = clampPct(Th_L);
    thLd = thLc;
    if (thLc >= thHc) thLd = (thHc == '0) ? '0 : thHc - TH_W'(1);
  end

  // Per-VC flow-control state register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= FLOW;
    end else begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= state_d[v];
    end
  end

  // Registered outputs, thresholds and round-robin pointer
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      thL_q     <= TH_W'(TH_L_RST);
      thH_q     <= TH_W'(TH_H_RST);
      rr_q      <= '0;
      dataOut_q <= '0;
      vcOut_q   <= '0;
      valid_q   <= 1'b0;
      pause_q   <= '0;
      cont_q    <= '0;
      err_q     <= '0;
      idle_q    <= 1'b1;
    end else begin
      if (Set_init) begin
        thL_q <= thLd;
        thH_q <= thHc;
      end
      valid_q <= popHit;
      if (popHit) begin
        dataOut_q <= head[popVc];
        vcOut_q   <= popVc;
        rr_q      <= popVc + VC_W'(1);
      end
      pause_q <= pauseD;
      cont_q  <= contD;
`ifdef STICKY_ERROR_EN
      err_q   <= Set_init ? '0 : (err_q | errD);
`else
      err_q   <= errD;
`endif
      idle_q  <= idleD;
    end
  end

  assign Data_out     = dataOut_q;
  assign VC_out       = vcOut_q;
  assign Valid_out    = valid_q;
  assign Pause_stb    = pause_q;
  assign Continue_stb = cont_q;
  assign Error_full   = err_q;
  assign Idle         = idle_q;

endmodule

// File: tb/tb_qos_vc_flow_ctrl.sv
// Self-checking bench for qos_vc_flow_ctrl: a queue-based reference model
// predicts every cycle's strobes, idle flag and popped words; popped words
// travel through a scoreboard queue until the DUT presents them.
module tb_qos_vc_flow_ctrl;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              Set_init;
  logic [6:0]        Th_L, Th_H;
  logic              Push_fifos;
  logic [1:0]        VC_ID;
  logic [DATA_W-1:0] DataWord;
  logic              Pop_buffer;
  logic [DATA_W-1:0] Data_out;
  logic [1:0]        VC_out;
  logic              Valid_out;
  logic [3:0]        Pause_stb, Continue_stb, Error_full;
  logic              Idle;

  qos_vc_flow_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Set_init     (Set_init),
    .Th_L         (Th_L),
    .Th_H         (Th_H),
    .Push_fifos   (Push_fifos),
    .VC_ID        (VC_ID),
    .DataWord     (DataWord),
    .Pop_buffer   (Pop_buffer),
    .Data_out     (Data_out),
    .VC_out       (VC_out),
    .Valid_out    (Valid_out),
    .Pause_stb    (Pause_stb),
    .Continue_stb (Continue_stb),
    .Error_full   (Error_full),
    .Idle         (Idle)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] mdl [4][$];
  logic [5:0]        sbQ [$];
  int                thL, thH, rr;
  bit   [3:0]        pausedM, errM;
  logic [DATA_W-1:0] lastData;
  logic [1:0]        lastVc;

  // Count one comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    for (int v = 0; v < 4; v++) mdl[v].delete();
    sbQ.delete();
    thL = 25; thH = 75; rr = 0;
    pausedM = '0; errM = '0;
    lastData = '0; lastVc = '0;
  endtask

  function automatic int mdlCount();
    int n = 0;
    for (int v = 0; v < 4; v++) n += mdl[v].size();
    return n;
  endfunction

  // Drive one cycle of inputs, advance the model, then check after the edge
  task automatic applyStimulus(input logic si, input logic [6:0] tl, input logic [6:0] th,
                               input logic psh, input logic [1:0] vc,
                               input logic [DATA_W-1:0] d, input logic pp);
    bit [3:0]          expPause, expCont;
    bit                expValid, expIdle, popHit;
    bit [1:0]          cand, popV;
    int                lo, hi, n;
    logic [DATA_W-1:0] word;
    logic [5:0]        exp;
    Set_init = si; Th_L = tl; Th_H = th; Push_fifos = psh;
    VC_ID = vc; DataWord = d; Pop_buffer = pp;
    expPause = '0; expCont = '0; popHit = 1'b0; popV = '0;
`ifndef STICKY_ERROR_EN
    errM = '0;
`endif
    if (si) begin
      for (int v = 0; v < 4; v++) mdl[v].delete();
      pausedM = '0; errM = '0;
      hi = (th > 100) ? 100 : int'(th);
      lo = (tl > 100) ? 100 : int'(tl);
      if (lo >= hi) lo = (hi == 0) ? 0 : hi - 1;
      thL = lo; thH = hi;
    end else begin
      if (pp) begin
        for (int i = 0; i < 4; i++) begin
          cand = 2'((rr + i) % 4);
          if (!popHit && mdl[cand].size() != 0) begin
            popHit = 1'b1;
            popV   = cand;
          end
        end
        if (popHit) begin
          word = mdl[popV].pop_front();
          sbQ.push_back({popV, word});
          lastData = word; lastVc = popV;
          rr = (int'(popV) + 1) % 4;
        end
      end
      if (psh) begin
        if (mdl[vc].size() < DEPTH) mdl[vc].push_back(d);
        else                        errM[vc] = 1'b1;
      end
      for (int v = 0; v < 4; v++) begin
        n = mdl[v].size();
        if (!pausedM[v] && n * 100 >= thH * DEPTH) begin
          pausedM[v] = 1'b1; expPause[v] = 1'b1;
        end else if (pausedM[v] && n * 100 <= thL * DEPTH) begin
          pausedM[v] = 1'b0; expCont[v] = 1'b1;
        end
      end
    end
    expValid = popHit;
    expIdle  = (mdlCount() == 0);
    @(posedge CLK); #1;
    checkOutput("valid", 32'(Valid_out), 32'(expValid));
    if (Valid_out && sbQ.size() != 0) begin
      exp = sbQ.pop_front();
      checkOutput("popWord", 32'({VC_out, Data_out}), 32'(exp));
    end else if (!Valid_out) begin
      checkOutput("dataHold", 32'({VC_out, Data_out}), 32'({lastVc, lastData}));
    end
    checkOutput("pause", 32'(Pause_stb), 32'(expPause));
    checkOutput("continue", 32'(Continue_stb), 32'(expCont));
    checkOutput("errorFull", 32'(Error_full), 32'(errM));
    checkOutput("idle", 32'(Idle), 32'(expIdle));
  endtask

  task automatic doPush(input logic [1:0] vc, input logic [DATA_W-1:0] d);
    applyStimulus(1'b0, 7'd0, 7'd0, 1'b1, vc, d, 1'b0);
  endtask

  task automatic doPop();
    applyStimulus(1'b0, 7'd0, 7'd0, 1'b0, 2'd0, '0, 1'b1);
  endtask

  task automatic doInit(input logic [6:0] tl, input logic [6:0] th);
    applyStimulus(1'b1, tl, th, 1'b0, 2'd0, '0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (mdlCount() > 0 && guard < 64) begin
      doPop();
      guard++;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Data"}, 32'({VC_out, Data_out, Valid_out}), 32'(0));
    checkOutput({tag, "Strobes"}, 32'({Pause_stb, Continue_stb, Error_full}), 32'(0));
    checkOutput({tag, "Idle"}, 32'(Idle), 32'(1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    Reset = 1'b1; Set_init = 1'b0; Th_L = '0; Th_H = '0;
    Push_fifos = 1'b0; VC_ID = '0; DataWord = '0; Pop_buffer = 1'b0;
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    checkResetState("reset");
    Reset = 1'b0;

    $display("[TB] watermark pause on VC0");
    doInit(7'd25, 7'd75);
    doPush(2'd0, 4'd0);
    doPush(2'd0, 4'd1);
    doPush(2'd0, 4'd2);

    $display("[TB] pop with continue on VC0");
    doPop();
    doPop();

    $display("[TB] overflow on VC1 and push+pop on a full FIFO");
    doPush(2'd1, 4'd5);
    doPush(2'd1, 4'd6);
    doPush(2'd1, 4'd7);
    doPush(2'd1, 4'd8);
    doPush(2'd1, 4'd9);
    applyStimulus(1'b0, 7'd0, 7'd0, 1'b1, 2'd1, 4'd10, 1'b1);
    drain();
    doPop();

    $display("[TB] round-robin across all VCs");
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    modelReset();
    for (int v = 0; v < 4; v++) doPush(2'(v), 4'(v + 1));
    repeat (5) doPop();

    $display("[TB] threshold sanitising");
    doInit(7'd80, 7'd60);
    doPush(2'd0, 4'd3);
    doPush(2'd0, 4'd4);
    doPush(2'd0, 4'd5);
    doPop();
    drain();
    doInit(7'd25, 7'd120);
    for (int i = 0; i < 4; i++) doPush(2'd0, 4'(i + 11));
    drain();

    $display("[TB] asynchronous reset while VC2 paused");
    doInit(7'd25, 7'd75);
    doPush(2'd2, 4'd12);
    doPush(2'd2, 4'd13);
    doPush(2'd2, 4'd14);
    Reset = 1'b1;
    #2;
    checkResetState("asyncRst");
    modelReset();
    @(posedge CLK); #1;
    checkOutput("rstNoContinue", 32'(Continue_stb), 32'(0));
    Reset = 1'b0;
    doPop();

    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
